// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory sequencer.
package lsu_pkg;

  // RV32I load/store funct3 encodings (stores reuse B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } lsu_state_e;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Stores only have B/H/W; the unsigned encodings exist only for loads.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    if (we) return !(funct3 inside {F3_B, F3_H, F3_W});
    else    return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

endpackage

// File: rtl/lsu_subword_lane.sv
// Byte/halfword lane logic: load extraction and store merge of one word.
module subword_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select by offset, then sign/zero extension by funct3
  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_o = {24'h0, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_o = {16'h0, half_sel};
      default: load_o = word_i;
    endcase
  end

  // Overlay store data onto the addressed lane of the read word
  always_comb begin
    merge_o = word_i;
    case (funct3_i)
      F3_B: merge_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H: begin
        if (offset_i[1]) merge_o[31:16] = wdata_i[15:0];
        else             merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Single-request load/store sequencer for a single-port synchronous memory,
// with read-modify-write for sub-word stores.
module lsu_mem_sequencer
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wbuf_q;     // store data, then read word / merged word
  logic              req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0]       resp_rdata_q;
  logic              mem_re_q, mem_we_q;

  logic              req_err;
  logic [31:0]       lane_load, lane_merge;

  assign req_err = is_misaligned(req_funct3, req_addr[1:0]) || is_illegal(req_we, req_funct3);

  // During CAP the lane sees the fresh read word and the held store data
  subword_lane u_lane (
    .word_i   (mem_rdata),
    .funct3_i (f3_q),
    .offset_i (addr_q[1:0]),
    .wdata_i  (wbuf_q),
    .load_o   (lane_load),
    .merge_o  (lane_merge)
  );

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  // Bus is zeroed whenever no strobe is active
  assign mem_addr   = (mem_re_q | mem_we_q) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata  = mem_we_q ? wbuf_q : 32'h0;

  // Request FSM with registered handshake and memory strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wbuf_q       <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            f3_q        <= req_funct3;
            addr_q      <= req_addr;
            wbuf_q      <= req_wdata;
            req_ready_q <= 1'b0;
            if (req_err) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else if (req_we && req_funct3 == F3_W) begin
              state_q  <= S_WR;
              mem_we_q <= 1'b1;
            end else begin
              state_q  <= S_RD;
              mem_re_q <= 1'b1;
            end
          end
        end
        S_RD: begin
          mem_re_q <= 1'b0;
          state_q  <= S_CAP;
        end
        S_CAP: begin
          if (we_q) begin
            wbuf_q   <= lane_merge;
            mem_we_q <= 1'b1;
            state_q  <= S_WR;
          end else begin
            wbuf_q       <= mem_rdata;
            resp_rdata_q <= lane_load;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_WR: begin
          mem_we_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 32'h0;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_sequencer.md
# lsu_mem_sequencer

Multi-cycle controller between the core's memory stage and a single-port synchronous data memory. Accepts one load/store request at a time, sequences the memory reads and writes it needs (including read-modify-write for SB/SH), does sub-word extraction and merging, and flags misaligned or illegal accesses. Returns the result through a valid/ready response port.

## Interface
- ADDR_W, 32, byte-address width; memory word address is `addr[ADDR_W-1:2]`.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data (rs2)
- resp_valid  out  1  response held until accepted
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned or illegal funct3
- mem_addr  out  ADDR_W  word-aligned address, low two bits always 0
- mem_re  out  1  read strobe; data on mem_rdata in the following cycle
- mem_we  out  1  full-word write strobe
- mem_wdata  out  32  word to write
- mem_rdata  in  32  read data

## Operation
- Request fields are captured on the accept edge (`req_valid && req_ready`). After that, the inputs are don't-care.
- Legal funct3 values:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Any other value is illegal.
- Misaligned accesses:
  - Halfword access with `addr[0]=1`.
  - Word access with `addr[1:0]!=0`.
- FSM states: IDLE, RD, CAP, WR, RESP.
- IDLE → RESP when the request is an error. No memory strobe is issued and `resp_err=1`.
- IDLE → RD for a load, SB or SH.
- IDLE → WR for SW. `mem_wdata = req_wdata`.
- RD: `mem_re=1`, `mem_addr` is valid. Next state is CAP.
- CAP: `mem_rdata` is registered into the word buffer.
  - Load → RESP. Result is extracted by `addr[1:0]`: LB/LBU select byte lane `addr[1:0]`; LH/LHU select `addr[1]`. LB/LH sign-extend; LBU/LHU zero-extend.
  - SB/SH → WR. The buffer is merged with `wdata[7:0]` or `wdata[15:0]` at that lane.
- WR: `mem_we=1` for exactly one cycle, with `mem_addr` and the merged word. Next state is RESP.
- RESP: `resp_valid=1`, with `resp_rdata` and `resp_err` stable. Moves to IDLE on `resp_ready`.
- Outside RD, `mem_re=0`. Outside WR, `mem_we=0`. `mem_addr` and `mem_wdata` are 0 when no strobe is active.

## Timing
- Accept edge = cycle 0. `resp_valid` first rises:
  - Error: cycle 1.
  - SW: cycle 2.
  - Load: cycle 3.
  - SB/SH: cycle 4.
- Response handshake: if `resp_ready` is already high, `resp_valid` lasts one cycle. The next request can be accepted in the cycle after the handshake (IDLE).
- Back-to-back SW throughput: one request every 3 cycles.
- `resp_valid` is never dropped, and `resp_rdata`/`resp_err` never change, while `resp_ready=0`.
- Memory is assumed exclusive to this block. No stall input exists on the memory side.
- Reset (asynchronous, any state):
  - State → IDLE immediately.
  - `req_ready=1`; `resp_valid`, `resp_err`, `mem_re`, `mem_we` = 0.
  - `resp_rdata`, `mem_addr`, `mem_wdata`, and all buffers = 0.
  - An in-flight RMW is abandoned with no write, so memory is unchanged if reset is asserted before WR.
  - Reset is deasserted with a synchronous release; the first accept is possible on the first edge after release.

## Structure
- `lsu_pkg` holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The FSM state enum `lsu_state_e`.
  - An `is_misaligned(funct3, addr[1:0])` function.
- Sub-module `subword_lane` (combinational): inputs word, funct3, offset, wdata; outputs the extracted load value and the merged store word. It is instantiated once and shared by CAP for both the load and the store paths.
- Sequential logic (FSM, captured request, word buffer, response registers) lives in `lsu_mem_sequencer`.

## Test plan
- Reset value is `mem[0x40]=0x8899AABB`. LB at 0x41 → `resp_rdata=0xFFFFFFAA` at cycle 3, one `mem_re` pulse, `mem_addr=0x40`. LBU at 0x43 → `0x00000088`.
- `mem[0x10]=0x11223344`. SB 0xA5 at 0x12 → RD, then WR with `mem_wdata=0x11A53344` at cycle 3, and `resp_valid` at cycle 4 with `resp_rdata=0`. SH 0xBEEF at 0x10 → `0x1122BEEF`.
- SW at 0x20, data 0xDEADBEEF → `mem_we` at cycle 1, `resp_valid` at cycle 2, no `mem_re` pulse.
- LW at 0x22, SH at 0x31, and funct3=011 → `resp_err=1` at cycle 1, with `mem_re` and `mem_we` never asserted.
- LH at 0x42 with `resp_ready` held low for 5 cycles → `resp_valid` and `resp_rdata=0xFFFF8899` stay stable throughout, and `req_ready` stays low until the cycle after the handshake.
- `rst_n` asserted during CAP of an SB → `mem_we` is never pulsed, memory is unchanged, and all outputs are at reset values without waiting for a clock edge.
